spm_dma_engine: RTL and testbench



---
 rtl/spm_dma_pkg.sv | 26 ++
 rtl/spm_dma_engine.sv | 190 +++++++++++++++++++
 tb/tb_spm_dma_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spm_dma_pkg.sv
// Shared constants for the SPM DMA engine: default widths, FSM state encodings and transfer directions.
package spm_dma_pkg;

    localparam int unsigned DATASIZE     = 128;
    localparam int unsigned ADDRSIZE     = 20;
    localparam int unsigned EXT_ADDRSIZE = 32;
    localparam int unsigned LENSIZE      = 16;

    localparam int unsigned STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_ACQUIRE = 4'd1;
    localparam state_t S_LD_REQ  = 4'd2;
    localparam state_t S_LD_WAIT = 4'd3;
    localparam state_t S_LD_WR   = 4'd4;
    localparam state_t S_ST_RD   = 4'd5;
    localparam state_t S_ST_CAP  = 4'd6;
    localparam state_t S_ST_REQ  = 4'd7;
    localparam state_t S_RELEASE = 4'd8;
    localparam state_t S_DONE    = 4'd9;

    localparam logic DIR_LOAD  = 1'b0;
    localparam logic DIR_STORE = 1'b1;

endpackage

// File: rtl/spm_dma_engine.sv
// DMA initiator on the scratchpad DMA port: moves word blocks between external memory and the SPM,
// holding the SPM port (CPU stalled) for the whole transfer.
module spm_dma_engine #(
    parameter int unsigned DATASIZE     = spm_dma_pkg::DATASIZE,
    parameter int unsigned ADDRSIZE     = spm_dma_pkg::ADDRSIZE,
    parameter int unsigned EXT_ADDRSIZE = spm_dma_pkg::EXT_ADDRSIZE,
    parameter int unsigned LENSIZE      = spm_dma_pkg::LENSIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [EXT_ADDRSIZE-1:0] cmd_ext_addr,
    input  logic [ADDRSIZE-1:0]     cmd_spm_addr,
    input  logic [LENSIZE-1:0]      cmd_len,
    output logic                    busy,
    output logic                    done,
    output logic                    dma_access,
    input  logic                    spm_stall,
    output logic                    dma_wr,
    output logic [ADDRSIZE-1:0]     dma_addr,
    output logic [DATASIZE-1:0]     dma_din,
    input  logic [DATASIZE-1:0]     dma_dout,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [EXT_ADDRSIZE-1:0] mem_addr,
    output logic [DATASIZE-1:0]     mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATASIZE-1:0]     mem_rdata
);
    import spm_dma_pkg::*;

    state_t                    state_q, state_d;
    logic                      dir_q, dir_d;
    logic [EXT_ADDRSIZE-1:0]   ext_ptr_q, ext_ptr_d;
    logic [ADDRSIZE-1:0]       spm_ptr_q, spm_ptr_d;
    logic [LENSIZE-1:0]        rem_q, rem_d;
    logic [DATASIZE-1:0]       data_q, data_d;

    logic                      cmd_ready_q, cmd_ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      dma_access_q, dma_access_d;
    logic                      dma_wr_q, dma_wr_d;
    logic [ADDRSIZE-1:0]       dma_addr_q, dma_addr_d;
    logic [DATASIZE-1:0]       dma_din_q, dma_din_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_we_q, mem_we_d;
    logic [EXT_ADDRSIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [DATASIZE-1:0]       mem_wdata_q, mem_wdata_d;

    logic                      last_c;

    assign last_c = (rem_q == LENSIZE'(1));

    // Next state plus datapath; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        ext_ptr_d = ext_ptr_q;
        spm_ptr_d = spm_ptr_q;
        rem_d     = rem_q;
        data_d    = data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d     = cmd_dir;
                    ext_ptr_d = cmd_ext_addr;
                    spm_ptr_d = cmd_spm_addr;
                    rem_d     = cmd_len;
                    state_d   = (cmd_len == '0) ? S_DONE : S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                if (spm_stall) begin
                    state_d = (dir_q == DIR_STORE) ? S_ST_RD : S_LD_REQ;
                end
            end
            S_LD_REQ: begin
                if (mem_gnt) begin
                    state_d = S_LD_WAIT;
                end
            end
            S_LD_WAIT: begin
                if (mem_rvalid) begin
                    data_d  = mem_rdata;
                    state_d = S_LD_WR;
                end
            end
            S_LD_WR: begin
                ext_ptr_d = ext_ptr_q + EXT_ADDRSIZE'(1);
                spm_ptr_d = spm_ptr_q + ADDRSIZE'(1);
                rem_d     = rem_q - LENSIZE'(1);
                state_d   = last_c ? S_RELEASE : S_LD_REQ;
            end
            S_ST_RD: begin
                state_d = S_ST_CAP;
            end
            S_ST_CAP: begin
                data_d  = dma_dout;
                state_d = S_ST_REQ;
            end
            S_ST_REQ: begin
                if (mem_gnt) begin
                    ext_ptr_d = ext_ptr_q + EXT_ADDRSIZE'(1);
                    spm_ptr_d = spm_ptr_q + ADDRSIZE'(1);
                    rem_d     = rem_q - LENSIZE'(1);
                    state_d   = last_c ? S_RELEASE : S_ST_RD;
                end
            end
            S_RELEASE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        dma_access_d = (state_d != S_IDLE) && (state_d != S_DONE);
        dma_wr_d     = (state_d == S_LD_WR);
        dma_addr_d   = ((state_d == S_LD_WR) || (state_d == S_ST_RD)) ? spm_ptr_d : '0;
        dma_din_d    = (state_d == S_LD_WR) ? data_d : '0;
        mem_req_d    = (state_d == S_LD_REQ) || (state_d == S_ST_REQ);
        mem_we_d     = (state_d == S_ST_REQ);
        mem_addr_d   = mem_req_d ? ext_ptr_d : '0;
        mem_wdata_d  = mem_we_d ? data_d : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            dir_q        <= DIR_LOAD;
            ext_ptr_q    <= '0;
            spm_ptr_q    <= '0;
            rem_q        <= '0;
            data_q       <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dma_access_q <= 1'b0;
            dma_wr_q     <= 1'b0;
            dma_addr_q   <= '0;
            dma_din_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            ext_ptr_q    <= ext_ptr_d;
            spm_ptr_q    <= spm_ptr_d;
            rem_q        <= rem_d;
            data_q       <= data_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dma_access_q <= dma_access_d;
            dma_wr_q     <= dma_wr_d;
            dma_addr_q   <= dma_addr_d;
            dma_din_q    <= dma_din_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dma_access = dma_access_q;
    assign dma_wr     = dma_wr_q;
    assign dma_addr   = dma_addr_q;
    assign dma_din    = dma_din_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_spm_dma_engine.sv
// Directed bench for spm_dma_engine: external-memory and SPM models with write scoreboards,
// handshake-stability and port-ownership monitors.
module tb_spm_dma_engine;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_t;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_dir;
    logic [31:0]  cmd_ext_addr;
    logic [19:0]  cmd_spm_addr;
    logic [15:0]  cmd_len;
    logic         busy;
    logic         done;
    logic         dma_access;
    logic         spm_stall;
    logic         dma_wr;
    logic [19:0]  dma_addr;
    logic [127:0] dma_din;
    logic [127:0] dma_dout;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    int gnt_delay   = 0;
    int rv_lat      = 2;
    int stall_extra = 0;
    int wait_cnt;
    int rd_cnt;
    int stall_cnt;
    logic [127:0] rd_data;

    logic [127:0] ext_mem [logic [31:0]];
    logic [127:0] spm_mem [logic [19:0]];
    wr_t spm_exp[$];
    wr_t ext_exp[$];

    int done_cnt      = 0;
    int access_cycles = 0;
    int req_cycles    = 0;
    int dma_wr_cnt    = 0;

    logic         granted;
    logic         prev_pend;
    logic [31:0]  prev_addr;
    logic         prev_we;
    logic [127:0] prev_wdata;

    spm_dma_engine dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .cmd_ext_addr (cmd_ext_addr),
        .cmd_spm_addr (cmd_spm_addr),
        .cmd_len      (cmd_len),
        .busy         (busy),
        .done         (done),
        .dma_access   (dma_access),
        .spm_stall    (spm_stall),
        .dma_wr       (dma_wr),
        .dma_addr     (dma_addr),
        .dma_din      (dma_din),
        .dma_dout     (dma_dout),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ext_rd(input logic [31:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : 128'h0;
    endfunction

    function automatic logic [127:0] spm_rd(input logic [19:0] a);
        return spm_mem.exists(a) ? spm_mem[a] : 128'h0;
    endfunction

    // External memory: grant after gnt_delay waiting cycles, read data rv_lat cycles after grant.
    assign mem_gnt = mem_req && (wait_cnt >= gnt_delay);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= 0;
            rd_cnt     <= 0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            rd_data    <= '0;
        end else begin
            wait_cnt   <= (mem_req && !mem_gnt) ? wait_cnt + 1 : 0;
            mem_rvalid <= 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt <= rd_cnt - 1;
                if (rd_cnt == 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= rd_data;
                end
            end
            if (mem_req && mem_gnt) begin
                if (mem_we) begin
                    ext_mem[mem_addr] = mem_wdata;
                end else if (rv_lat <= 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= ext_rd(mem_addr);
                end else begin
                    rd_data <= ext_rd(mem_addr);
                    rd_cnt  <= rv_lat - 1;
                end
            end
        end
    end

    // SPM: stall follows dma_access after 1+stall_extra cycles, synchronous read port.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            spm_stall <= 1'b0;
            stall_cnt <= 0;
            dma_dout  <= '0;
        end else begin
            if (!dma_access) begin
                spm_stall <= 1'b0;
                stall_cnt <= 0;
            end else if (stall_cnt >= stall_extra) begin
                spm_stall <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 1;
            end
            dma_dout <= spm_rd(dma_addr);
            if (dma_wr) spm_mem[dma_addr] = dma_din;
        end
    end

    // Monitor: scoreboards, request stability, no port activity before the stall grant.
    always @(negedge clk) begin
        if (!rst) begin
            prev_pend = 1'b0;
            granted   = 1'b0;
        end else begin
            if (dma_access) access_cycles++;
            if (mem_req) req_cycles++;
            if (done) begin
                done_cnt++;
                check("access_low_at_done", 128'(dma_access), 128'(0));
            end
            if (dma_wr) begin
                dma_wr_cnt++;
                check("spm_wr_expected", 128'(spm_exp.size() != 0), 128'(1));
                if (spm_exp.size() != 0) begin
                    wr_t e;
                    e = spm_exp.pop_front();
                    check("spm_wr_addr", 128'(dma_addr), 128'(e.addr[19:0]));
                    check("spm_wr_data", dma_din, e.data);
                end
            end
            if (mem_req && mem_gnt && mem_we) begin
                check("ext_wr_expected", 128'(ext_exp.size() != 0), 128'(1));
                if (ext_exp.size() != 0) begin
                    wr_t e;
                    e = ext_exp.pop_front();
                    check("ext_wr_addr", 128'(mem_addr), 128'(e.addr));
                    check("ext_wr_data", mem_wdata, e.data);
                end
            end
            if (prev_pend) begin
                check("req_held", 128'(mem_req), 128'(1));
                check("req_addr_stable", 128'(mem_addr), 128'(prev_addr));
                check("req_we_stable", 128'(mem_we), 128'(prev_we));
                check("req_wdata_stable", mem_wdata, prev_wdata);
            end
            if (mem_req || dma_wr) check("port_used_after_grant", 128'(granted), 128'(1));
            if (!dma_access) granted = 1'b0;
            else if (spm_stall) granted = 1'b1;
            prev_pend  = mem_req && !mem_gnt;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
        end
    end

    task automatic issue(input logic dir, input logic [31:0] ea, input logic [19:0] sa,
                         input logic [15:0] len);
        @(negedge clk);
        check("cmd_ready_idle", 128'(cmd_ready), 128'(1));
        cmd_valid    = 1'b1;
        cmd_dir      = dir;
        cmd_ext_addr = ea;
        cmd_spm_addr = sa;
        cmd_len      = len;
        @(negedge clk);
        cmd_valid    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 128'(done === 1'b1), 128'(1));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 128'(done), 128'(0));
        check({tag, "_idle_after"}, 128'(busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, r0, w0, n;
        logic seen;
        rst          = 1'b0;
        cmd_valid    = 1'b0;
        cmd_dir      = 1'b0;
        cmd_ext_addr = '0;
        cmd_spm_addr = '0;
        cmd_len      = '0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_dma_access", 128'(dma_access), 128'(0));
        check("rst_mem_req", 128'(mem_req), 128'(0));
        check("rst_dma_wr", 128'(dma_wr), 128'(0));
        check("rst_dma_addr", 128'(dma_addr), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        rst = 1'b1;

        // Load 4 words, ext 0x100 -> spm 0x10, rvalid 2 cycles after grant
        for (int i = 0; i < 4; i++) begin
            ext_mem[32'h100 + 32'(i)] = 128'(32'hA0 + 32'(i));
            spm_exp.push_back('{addr: 32'h10 + 32'(i), data: 128'(32'hA0 + 32'(i))});
        end
        d0 = done_cnt; a0 = access_cycles;
        issue(1'b0, 32'h100, 20'h00010, 16'd4);
        check("load_busy", 128'(busy), 128'(1));
        check("load_access_next_cycle", 128'(dma_access), 128'(1));
        wait_done("load", 200);
        check("load_done_once", 128'(done_cnt - d0), 128'(1));
        check("load_access_seen", 128'(access_cycles > a0), 128'(1));
        check("load_sb_empty", 128'(spm_exp.size()), 128'(0));
        check("load_spm_13", spm_rd(20'h00013), 128'hA3);

        // Store 2 words, spm 0x20 -> ext 0x200
        spm_mem[20'h00020] = 128'h55;
        spm_mem[20'h00021] = 128'h66;
        ext_exp.push_back('{addr: 32'h200, data: 128'h55});
        ext_exp.push_back('{addr: 32'h201, data: 128'h66});
        w0 = dma_wr_cnt;
        issue(1'b1, 32'h200, 20'h00020, 16'd2);
        wait_done("store", 200);
        check("store_no_dma_wr", 128'(dma_wr_cnt - w0), 128'(0));
        check("store_sb_empty", 128'(ext_exp.size()), 128'(0));
        check("store_ext_201", ext_rd(32'h201), 128'h66);

        // Zero length: done in the cycle after accept, port and memory untouched
        a0 = access_cycles; r0 = req_cycles; d0 = done_cnt;
        issue(1'b0, 32'h900, 20'h00090, 16'd0);
        check("len0_done_next_cycle", 128'(done), 128'(1));
        check("len0_no_access", 128'(dma_access), 128'(0));
        wait_done("len0", 4);
        check("len0_access_never", 128'(access_cycles - a0), 128'(0));
        check("len0_req_never", 128'(req_cycles - r0), 128'(0));
        check("len0_done_once", 128'(done_cnt - d0), 128'(1));

        // SPM address wrap
        ext_mem[32'h300] = 128'hC0FFEE_0001;
        ext_mem[32'h301] = 128'hC0FFEE_0002;
        spm_exp.push_back('{addr: 32'hFFFFF, data: 128'hC0FFEE_0001});
        spm_exp.push_back('{addr: 32'h00000, data: 128'hC0FFEE_0002});
        rv_lat = 1;
        issue(1'b0, 32'h300, 20'hFFFFF, 16'd2);
        wait_done("wrap", 200);
        check("wrap_sb_empty", 128'(spm_exp.size()), 128'(0));
        check("wrap_spm_0", spm_rd(20'h00000), 128'hC0FFEE_0002);

        // Backpressure: slow grant and late stall, load then store
        gnt_delay = 5; stall_extra = 3; rv_lat = 2;
        ext_mem[32'h600] = 128'h1111;
        ext_mem[32'h601] = 128'h2222;
        spm_exp.push_back('{addr: 32'h60, data: 128'h1111});
        spm_exp.push_back('{addr: 32'h61, data: 128'h2222});
        issue(1'b0, 32'h600, 20'h00060, 16'd2);
        wait_done("bp_load", 400);
        check("bp_load_sb_empty", 128'(spm_exp.size()), 128'(0));
        ext_exp.push_back('{addr: 32'h700, data: 128'h55});
        issue(1'b1, 32'h700, 20'h00020, 16'd1);
        wait_done("bp_store", 400);
        check("bp_store_sb_empty", 128'(ext_exp.size()), 128'(0));
        gnt_delay = 0; stall_extra = 0;

        // Reset while waiting for the second of four load words
        rv_lat = 3;
        for (int i = 0; i < 4; i++) ext_mem[32'h400 + 32'(i)] = 128'(32'hB0 + 32'(i));
        spm_exp.push_back('{addr: 32'h40, data: 128'hB0});
        issue(1'b0, 32'h400, 20'h00040, 16'd4);
        n = 0;
        seen = 1'b0;
        while (n < 100) begin
            if (mem_req && mem_gnt && !mem_we) begin
                if (seen) break;
                seen = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        check("rst_mid_second_read_seen", 128'(n < 100), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_access_drop", 128'(dma_access), 128'(0));
        check("rst_mid_req_drop", 128'(mem_req), 128'(0));
        check("rst_mid_cmd_ready", 128'(cmd_ready), 128'(1));
        check("rst_mid_sb_empty", 128'(spm_exp.size()), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ext_mem[32'h500] = 128'hDEAD_BEEF;
        spm_exp.push_back('{addr: 32'h50, data: 128'hDEAD_BEEF});
        issue(1'b0, 32'h500, 20'h00050, 16'd1);
        wait_done("post_rst", 200);
        check("post_rst_sb_empty", 128'(spm_exp.size()), 128'(0));
        check("post_rst_no_stale_41", 128'(spm_mem.exists(20'h00041)), 128'(0));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
